// File: rtl/lbp_window_engine.sv
// LBP window engine: raster-scans a gray frame through a 3x3 window
// and writes one 8-bit local binary pattern code per pixel.
module lbp_window_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  input  logic [PIX_W-1:0]  cfg_thresh,
  input  logic              cfg_border,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic [PIX_W-1:0]  gray_data,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_valid,
  output logic [7:0]        lbp_data,
  output logic              finish,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_WRITE, S_BORDER, S_DONE
  } state_t;

  localparam int MXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW  = $clog2(MXD) + 1;
  localparam logic [CW-1:0] XL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] XI = CW'(IMG_W - 2);
  localparam logic [CW-1:0] YL = CW'(IMG_H - 1);
  localparam logic [CW-1:0] YI = CW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] LW = ADDR_W'(IMG_W);

  state_t              r_state, w_next;
  logic [CW-1:0]       r_x, r_y;
  logic [1:0]          r_ri, r_ci;
  logic [PIX_W-1:0]    r_thr;
  logic                r_bdr;
  logic [PIX_W-1:0]    r_win  [0:2][0:2];
  logic [PIX_W-1:0]    w_nwin [0:2][0:2];
  logic [ADDR_W-1:0]   r_lbp_addr;
  logic [7:0]          r_lbp_data;

  logic [CW-1:0]       w_xmax, w_xmin, w_nx, w_ny;
  logic                w_eol, w_last, w_nbrd, w_cell_end;
  logic [ADDR_W-1:0]   w_row, w_col, w_rd_addr;
  logic [ADDR_W-1:0]   w_cur_addr, w_nxt_addr;
  logic [PIX_W:0]      w_sum;
  logic [7:0]          w_code;

  // next scan position and frame-end detection
  always_comb begin
    w_xmax = r_bdr ? XL : XI;
    w_xmin = r_bdr ? '0 : CW'(1);
    w_eol  = (r_x == w_xmax);
    w_nx   = w_eol ? w_xmin : r_x + CW'(1);
    w_ny   = w_eol ? r_y + CW'(1) : r_y;
    w_last = r_bdr ? (r_x == XL && r_y == YL)
                   : (r_x == XI && r_y == YI);
    w_nbrd = r_bdr && (w_nx == '0 || w_ny == '0 ||
                       w_nx == XL || w_ny == YL);
    w_cell_end = (r_ri == 2'd2) &&
                 (r_state == S_SHIFT || r_ci == 2'd2);
  end

  // read and write address arithmetic
  always_comb begin
    w_row = ADDR_W'(r_y) + ADDR_W'(r_ri) - ADDR_W'(1);
    if (r_state == S_LOAD)
      w_col = ADDR_W'(r_x) + ADDR_W'(r_ci) - ADDR_W'(1);
    else
      w_col = ADDR_W'(r_x) + ADDR_W'(1);
    w_rd_addr  = w_row * LW + w_col;
    w_cur_addr = ADDR_W'(r_y) * LW + ADDR_W'(r_x);
    w_nxt_addr = ADDR_W'(w_ny) * LW + ADDR_W'(w_nx);
  end

  // window as it will look after this cycle's read
  always_comb begin
    w_nwin = r_win;
    if (r_state == S_LOAD) begin
      w_nwin[r_ri][r_ci] = gray_data;
    end else if (r_state == S_SHIFT) begin
      w_nwin[r_ri][0] = r_win[r_ri][1];
      w_nwin[r_ri][1] = r_win[r_ri][2];
      w_nwin[r_ri][2] = gray_data;
    end
  end

  // pattern code; the widened sum keeps an overflowing
  // threshold from wrapping, so such bits stay 0
  always_comb begin
    w_sum = {1'b0, w_nwin[1][1]} + {1'b0, r_thr};
    w_code[0] = {1'b0, w_nwin[0][0]} >= w_sum;
    w_code[1] = {1'b0, w_nwin[0][1]} >= w_sum;
    w_code[2] = {1'b0, w_nwin[0][2]} >= w_sum;
    w_code[3] = {1'b0, w_nwin[1][0]} >= w_sum;
    w_code[4] = {1'b0, w_nwin[1][2]} >= w_sum;
    w_code[5] = {1'b0, w_nwin[2][0]} >= w_sum;
    w_code[6] = {1'b0, w_nwin[2][1]} >= w_sum;
    w_code[7] = {1'b0, w_nwin[2][2]} >= w_sum;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (gray_ready)
          w_next = cfg_border ? S_BORDER : S_LOAD;
      S_LOAD, S_SHIFT:
        if (w_cell_end) w_next = S_WRITE;
      S_WRITE, S_BORDER:
        if (w_last)      w_next = S_DONE;
        else if (w_nbrd) w_next = S_BORDER;
        else if (w_nx == CW'(1)) w_next = S_LOAD;
        else             w_next = S_SHIFT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    gray_req  = (r_state == S_LOAD) || (r_state == S_SHIFT);
    gray_addr = gray_req ? w_rd_addr : '0;
    lbp_valid = (r_state == S_WRITE) || (r_state == S_BORDER);
    finish    = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    lbp_addr  = r_lbp_addr;
    lbp_data  = r_lbp_data;
  end

  // scan position, window cells and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
      r_ri <= '0;
      r_ci <= '0;
      r_thr <= '0;
      r_bdr <= 1'b0;
      r_lbp_addr <= '0;
      r_lbp_data <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
    end else begin
      r_win <= w_nwin;
      unique case (r_state)
        S_IDLE:
          if (gray_ready) begin
            r_thr <= cfg_thresh;
            r_bdr <= cfg_border;
            r_x <= cfg_border ? '0 : CW'(1);
            r_y <= cfg_border ? '0 : CW'(1);
            r_ri <= '0;
            r_ci <= '0;
          end
        S_LOAD:
          if (r_ci == 2'd2) begin
            r_ci <= '0;
            r_ri <= (r_ri == 2'd2) ? 2'd0 : r_ri + 2'd1;
          end else begin
            r_ci <= r_ci + 2'd1;
          end
        S_SHIFT:
          r_ri <= (r_ri == 2'd2) ? 2'd0 : r_ri + 2'd1;
        S_WRITE, S_BORDER:
          if (!w_last) begin
            r_x <= w_nx;
            r_y <= w_ny;
          end
        default: ;
      endcase
      if (w_next == S_WRITE) begin
        r_lbp_addr <= w_cur_addr;
        r_lbp_data <= w_code;
      end else if (w_next == S_BORDER) begin
        r_lbp_addr <= (r_state == S_IDLE) ? '0 : w_nxt_addr;
        r_lbp_data <= '0;
      end
    end
  end

endmodule
